// File: rtl/fft_out_reorder_if.sv
`default_nettype none
// ============================================================================
//  Module      : fft_out_reorder_if
//  Description : Stream bundle around the FFT output reorder buffer. It carries
//                the bit-reversed input stream from the FFT core and the
//                natural-order output stream.
//  Revision    : 1.0  initial release
// ============================================================================
interface fft_out_reorder_if #(
    parameter int X_WDTH = 16
);
    logic [2*X_WDTH-1:0] din;
    logic                din_nd;
    logic                overflow_in;
    logic [2*X_WDTH-1:0] dout;
    logic                dout_nd;
    logic                dout_first;
    logic                overflow_out;

    // Environment view: drives the FFT-side stream and observes the output
    modport master (
        output din, din_nd, overflow_in,
        input  dout, dout_nd, dout_first, overflow_out
    );

    // Reorder buffer view
    modport slave (
        input  din, din_nd, overflow_in,
        output dout, dout_nd, dout_first, overflow_out
    );
endinterface
`default_nettype wire

// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : fft_out_reorder
//  Description : Ping-pong reorder buffer. It takes the FFT core's
//                bit-reversed output and re-emits every N-point frame as an
//                unbroken N-cycle burst in natural bin order. The burst carries
//                a first-bin marker and the overflow flag for that frame.
//  Revision    : 1.0  initial release
// ============================================================================
module fft_out_reorder #(
    parameter int N      = 8,
    parameter int NLOG2  = 3,
    parameter int X_WDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    fft_out_reorder_if.slave    bus
);
    localparam int               c_DW   = 2 * X_WDTH;
    localparam logic [NLOG2-1:0] c_LAST = NLOG2'(N - 1);
    localparam logic [NLOG2-1:0] c_ONE  = NLOG2'(1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } rd_state_t;

    // Two banks of N words. The bank bit is the address MSB.
    logic [c_DW-1:0]  r_mem [0:2*N-1];

    logic [NLOG2-1:0] r_wr_cnt;
    logic             r_wr_bank;
    logic             r_wr_sticky;

    rd_state_t        r_state;
    logic [NLOG2-1:0] r_rd_cnt;
    logic             r_rd_bank;
    logic             r_rd_sticky;

    logic [c_DW-1:0]  r_dout;
    logic             r_dout_nd;
    logic             r_dout_first;
    logic             r_overflow_out;

    logic [NLOG2-1:0] w_wr_addr_rev;
    logic             w_frame_done;

    // Sample k of the frame belongs at bin bitrev(k)
    generate
        for (genvar gi = 0; gi < NLOG2; gi++) begin : g_bitrev
            assign w_wr_addr_rev[gi] = r_wr_cnt[NLOG2-1-gi];
        end
    endgenerate

    assign w_frame_done = bus.din_nd && (r_wr_cnt == c_LAST);

    // Buffer write. The contents need no reset because every word is
    // rewritten before its bank is ever read.
    always_ff @(posedge clk) begin
        if (bus.din_nd) begin
            r_mem[{r_wr_bank, w_wr_addr_rev}] <= bus.din;
        end
    end

    // Write side: arrival counter, bank select and per-frame sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_cnt    <= '0;
            r_wr_bank   <= 1'b0;
            r_wr_sticky <= 1'b0;
        end else if (bus.din_nd) begin
            r_wr_cnt <= r_wr_cnt + c_ONE;
            if (w_frame_done) begin
                // The completed frame's flag moves to the read side, and the
                // next frame starts clean.
                r_wr_bank   <= ~r_wr_bank;
                r_wr_sticky <= 1'b0;
            end else begin
                r_wr_sticky <= r_wr_sticky | bus.overflow_in;
            end
        end
    end

    // Read side: issue addresses 0..N-1 back to back and register the RAM output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_rd_cnt       <= '0;
            r_rd_bank      <= 1'b0;
            r_rd_sticky    <= 1'b0;
            r_dout         <= '0;
            r_dout_nd      <= 1'b0;
            r_dout_first   <= 1'b0;
            r_overflow_out <= 1'b0;
        end else begin
            case (r_state)
                S_BURST: begin
                    r_dout       <= r_mem[{r_rd_bank, r_rd_cnt}];
                    r_dout_nd    <= 1'b1;
                    r_dout_first <= (r_rd_cnt == '0);
                    if (r_rd_cnt == '0) begin
                        r_overflow_out <= r_rd_sticky;
                    end
                    r_rd_cnt <= r_rd_cnt + c_ONE;
                    if (r_rd_cnt == c_LAST) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_dout_nd    <= 1'b0;
                    r_dout_first <= 1'b0;
                end
            endcase
            // A completed frame always starts a new burst. Back to back, this
            // coincides with the previous burst's last address.
            if (w_frame_done) begin
                r_state     <= S_BURST;
                r_rd_cnt    <= '0;
                r_rd_bank   <= r_wr_bank;
                r_rd_sticky <= r_wr_sticky | bus.overflow_in;
            end
        end
    end

    assign bus.dout         = r_dout;
    assign bus.dout_nd      = r_dout_nd;
    assign bus.dout_first   = r_dout_first;
    assign bus.overflow_out = r_overflow_out;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_out_reorder
//  Description : Self-checking bench for fft_out_reorder. An arrival-order
//                frame model predicts each output burst. Literal checks on
//                the directed frames pin the expected values.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_out_reorder;
    localparam int N     = 8;
    localparam int NLOG2 = 3;
    localparam int XW    = 16;

    typedef struct {
        int          cyc;
        logic [31:0] d;
        logic        first;
        logic        ovf;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    item_t exp_q[$];
    item_t obs_q[$];

    fft_out_reorder_if #(.X_WDTH(XW)) bif ();

    fft_out_reorder #(.N(N), .NLOG2(NLOG2), .X_WDTH(XW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    function automatic int bitrev(input int k);
        int r = 0;
        for (int b = 0; b < NLOG2; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (NLOG2 - 1 - b));
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model and per-cycle compare. A frame is collected in
    // natural-bin order as it arrives. When the frame completes, its N
    // outputs are scheduled 2..N+1 cycles after the last sample.
    initial begin : model_compare
        logic [31:0] frame [N];
        int          m_cnt;
        logic        m_sticky;
        logic [31:0] held_d;
        logic        held_ovf;
        item_t       e;
        m_cnt = 0; m_sticky = 1'b0; held_d = '0; held_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (bif.dout_nd === 1'b1) begin
                e.cyc = cyc; e.d = bif.dout; e.first = bif.dout_first; e.ovf = bif.overflow_out;
                obs_q.push_back(e);
            end
            if (rst_n !== 1'b1) begin
                exp_q.delete();
                m_cnt = 0; m_sticky = 1'b0; held_d = '0; held_ovf = 1'b0;
                chk("reset_dout_nd", {63'b0, bif.dout_nd}, 64'd0);
                chk("reset_dout_first", {63'b0, bif.dout_first}, 64'd0);
                chk("reset_dout", {32'b0, bif.dout}, 64'd0);
                chk("reset_overflow_out", {63'b0, bif.overflow_out}, 64'd0);
            end else begin
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    e = exp_q.pop_front();
                    chk("burst_dout_nd", {63'b0, bif.dout_nd}, 64'd1);
                    chk("burst_dout", {32'b0, bif.dout}, {32'b0, e.d});
                    chk("burst_dout_first", {63'b0, bif.dout_first}, {63'b0, e.first});
                    chk("burst_overflow_out", {63'b0, bif.overflow_out}, {63'b0, e.ovf});
                    held_d = e.d; held_ovf = e.ovf;
                end else begin
                    chk("idle_dout_nd", {63'b0, bif.dout_nd}, 64'd0);
                    chk("idle_dout_first", {63'b0, bif.dout_first}, 64'd0);
                    chk("idle_dout_hold", {32'b0, bif.dout}, {32'b0, held_d});
                    chk("idle_overflow_hold", {63'b0, bif.overflow_out}, {63'b0, held_ovf});
                end
                if (bif.din_nd === 1'b1) begin
                    frame[bitrev(m_cnt)] = bif.din;
                    m_sticky = m_sticky | bif.overflow_in;
                    if (m_cnt == N - 1) begin
                        for (int i = 0; i < N; i++) begin
                            e.cyc = cyc + 2 + i; e.d = frame[i]; e.first = (i == 0); e.ovf = m_sticky;
                            exp_q.push_back(e);
                        end
                        m_cnt = 0; m_sticky = 1'b0;
                    end else begin
                        m_cnt++;
                    end
                end
            end
            cyc++;
        end
    end

    // Drive the inputs for the cycle that has just begun
    task automatic drive(input logic nd, input logic [31:0] d, input logic ov);
        @(posedge clk);
        #1;
        bif.din_nd      = nd;
        bif.din         = d;
        bif.overflow_in = ov;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, $urandom, 1'b0);
    endtask

    // Send one frame so that bin b carries base+b. Returns the cycle of the last sample.
    task automatic send_frame(input int base, input int gap, input int ovf_k, output int t_last);
        for (int k = 0; k < N; k++) begin
            for (int g = 0; g < gap; g++) drive(1'b0, $urandom, 1'b0);
            drive(1'b1, 32'(base + bitrev(k)), (k == ovf_k));
            t_last = cyc;
        end
    endtask

    // Literal expectations on an observed burst: natural order, one marker,
    // flag, and contiguous timing from the required start cycle
    task automatic pin_frame(input int idx, input int base, input logic ovf, input int start_cyc);
        chk("pin_burst_present", {63'b0, obs_q.size() >= idx + N}, 64'd1);
        if (obs_q.size() >= idx + N) begin
            for (int i = 0; i < N; i++) begin
                chk("pin_value", {32'b0, obs_q[idx+i].d}, 64'(base + i));
                chk("pin_first", {63'b0, obs_q[idx+i].first}, {63'b0, (i == 0)});
                chk("pin_overflow", {63'b0, obs_q[idx+i].ovf}, {63'b0, ovf});
                chk("pin_cycle", 64'(obs_q[idx+i].cyc), 64'(start_cyc + i));
            end
        end
    endtask

    initial begin : stimulus
        int t1, t2, t3;
        bit seen;
        rst_n = 1'b0;
        bif.din = '0; bif.din_nd = 1'b0; bif.overflow_in = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Continuous single frame
        obs_q.delete();
        send_frame(0, 0, -1, t1);
        idle(12);
        pin_frame(0, 0, 1'b0, t1 + 2);
        chk("single_count", 64'(obs_q.size()), 64'd8);

        // Gapped single frame
        obs_q.delete();
        send_frame(0, 1, -1, t1);
        idle(12);
        pin_frame(0, 0, 1'b0, t1 + 2);

        // Three frames back to back
        obs_q.delete();
        send_frame(32'h500, 0, -1, t1);
        send_frame(32'h600, 0, -1, t2);
        send_frame(32'h700, 0, -1, t3);
        idle(12);
        chk("b2b_count", 64'(obs_q.size()), 64'd24);
        pin_frame(0,  32'h500, 1'b0, t1 + 2);
        pin_frame(8,  32'h600, 1'b0, t1 + 10);
        pin_frame(16, 32'h700, 1'b0, t1 + 18);

        // Overflow on sample 5 of frame 1 only
        obs_q.delete();
        send_frame(32'h300, 0, 5, t1);
        send_frame(32'h400, 0, -1, t2);
        idle(12);
        pin_frame(0, 32'h300, 1'b1, t1 + 2);
        pin_frame(8, 32'h400, 1'b0, t2 + 2);

        // Reset after a partial frame of 5 samples
        obs_q.delete();
        for (int k = 0; k < 5; k++) drive(1'b1, 32'(32'h900 + bitrev(k)), 1'b1);
        drive(1'b0, 0, 1'b0);
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        send_frame(32'h200, 0, -1, t1);
        idle(12);
        chk("partial_count", 64'(obs_q.size()), 64'd8);
        pin_frame(0, 32'h200, 1'b0, t1 + 2);

        // Reset in the middle of a burst, while bin 3 is on the output
        obs_q.delete();
        send_frame(32'h100, 0, 2, t1);
        drive(1'b0, 0, 1'b0);
        seen = 1'b0;
        for (int w = 0; w < 40 && !seen; w++) begin
            @(negedge clk);
            #1;
            if (obs_q.size() >= 4) seen = 1'b1;
        end
        chk("midburst_reached_bin3", {63'b0, seen}, 64'd1);
        if (seen) chk("midburst_bin3_value", {32'b0, obs_q[3].d}, 64'h103);
        rst_n = 1'b0;
        #1;
        chk("async_dout_nd", {63'b0, bif.dout_nd}, 64'd0);
        chk("async_dout_first", {63'b0, bif.dout_first}, 64'd0);
        chk("async_dout", {32'b0, bif.dout}, 64'd0);
        chk("async_overflow_out", {63'b0, bif.overflow_out}, 64'd0);
        idle(2);
        rst_n = 1'b1;
        obs_q.delete();
        idle(15);
        chk("no_residual_burst", 64'(obs_q.size()), 64'd0);

        // Randomized frames: random data, gaps, overflow and inter-frame spacing
        for (int f = 0; f < 20; f++) begin
            int mode;
            mode = $urandom_range(0, 2);
            for (int k = 0; k < N; k++) begin
                if (mode != 0) begin
                    int g;
                    g = $urandom_range(0, 3);
                    for (int j = 0; j < g; j++) drive(1'b0, $urandom, $urandom_range(0, 1));
                end
                drive(1'b1, $urandom, ($urandom_range(0, 15) == 0));
            end
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 12));
        end
        idle(20);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Hard cap on simulation time
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fft_out_reorder.md
Name: fft_out_reorder

Overview:
- Downstream of the dit FFT core; consumes its bit-reversed output stream (dout/dout_nd/overflow) and re-emits each N-point frame in natural bin order.
- Ping-pong buffer of 2 banks x N complex words: one bank is written while the other is read.
- Output of each frame is an unbroken N-cycle burst with a first-bin marker and a per-frame overflow flag.

Parameters:
- N, 8, FFT length (power of 2, >= 4)
- NLOG2, 3, log2(N)
- X_WDTH, 16, width of each real/imag component; complex word = 2*X_WDTH (real in upper half)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- din  in  2*X_WDTH  FFT output sample, bit-reversed bin order
- din_nd  in  1  din valid this cycle; may be gapped arbitrarily, max one per cycle
- overflow_in  in  1  FFT core overflow flag, sampled when din_nd=1
- dout  out  2*X_WDTH  reordered sample, natural bin order
- dout_nd  out  1  dout valid
- dout_first  out  1  high with dout_nd for bin 0 of each frame
- overflow_out  out  1  sticky overflow of the frame currently being output

Behaviour:
- Reset: async on rst_n low. dout=0, dout_nd=0, dout_first=0, overflow_out=0; write count=0, write bank=0, read inactive, sticky flag=0. Any partial input frame or burst in progress is discarded; no output until a full new frame is received after release.
- Write side: on clk with din_nd=1, the k-th sample of the frame (k=0..N-1, arrival order) goes to write-bank address bitrev_NLOG2(k). The sticky flag ORs in overflow_in. Write count increments and wraps at N.
- Frame complete: when sample k=N-1 is accepted at cycle t:
  - at t+1, banks swap, the read pointer is set to 0, and the frame's sticky value is latched to the read side;
  - the write sticky flag clears, so sample 0 of the next frame starts from 0 (a set in the swap cycle is counted for the new frame).
- Read side: addresses 0..N-1 are issued in cycles t+1..t+N, one per cycle, with a registered RAM read.
  - dout_nd=1 in cycles t+2..t+N+1.
  - dout_first=1 only at t+2.
  - overflow_out takes the latched frame value at t+2 and holds it until the next frame's first output.
  - dout holds its last value when dout_nd=0.
- Latency: the last input sample to bin 0 out is 2 cycles. The output burst is always N contiguous cycles regardless of input gaps.
- Back-to-back frames (din_nd continuously high): the next frame's last write is at t+N and its swap at t+N+1. The output is then continuous, with dout_first every N cycles.
- Collision rule: input can't complete a frame in fewer than N cycles, so a read never overlaps a write to the same bank. No backpressure and no input stall.
- Width rules: no arithmetic on data; bits pass unchanged. Addresses are NLOG2 bits plus 1 bank bit.
- din_nd=0 for any duration mid-frame: state is held, with no timeout.

Test Plan:
- N=8, reset, feed din = bin index (0,4,2,6,1,5,3,7 in arrival order) with din_nd continuous -> two cycles after the last input, dout = 0..7 on 8 consecutive cycles; dout_first only on value 0; overflow_out=0.
- Same frame with din_nd toggling 1/0 (gapped) -> identical contiguous 8-cycle output, starting 2 cycles after the 8th accepted sample.
- Three back-to-back frames with continuous din_nd -> 24 contiguous valid outputs, natural order per frame, dout_first at outputs 0, 8 and 16.
- overflow_in=1 only on sample 5 of frame 1, and 0 for frame 2 -> overflow_out=1 throughout frame 1's burst, then 0 from frame 2's first output.
- Assert rst_n low after 5 samples of a frame, then release and send a full frame -> no output from the partial frame; the new frame is output correctly with overflow_out=0.
- Assert rst_n low mid-burst (output bin 3) -> dout_nd, dout_first, dout and overflow_out go to 0 immediately (asynchronously), and no residual burst follows.
